// File: rtl/syndrome_sequencer.sv
// Splits syndrome beats from the switch into per-test-pattern transfers for the downstream decoder.
// Chase short codes carry two 4-syndrome test patterns per beat; everything else carries one per beat.
module syndrome_sequencer #(
   parameter int SETTLE_CYC = 1,
   parameter int SYM_W      = 10
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_mode,
   input  logic [1:0]       i_code,
   input  logic             i_start,
   input  logic [SYM_W-1:0] i_S1,
   input  logic [SYM_W-1:0] i_S2,
   input  logic [SYM_W-1:0] i_S3,
   input  logic [SYM_W-1:0] i_S4,
   input  logic [SYM_W-1:0] i_S5,
   input  logic [SYM_W-1:0] i_S6,
   input  logic [SYM_W-1:0] i_S7,
   input  logic [SYM_W-1:0] i_S8,
   input  logic             i_valid,
   output logic             o_next_tp,
   output logic [SYM_W-1:0] o_syn_S1,
   output logic [SYM_W-1:0] o_syn_S2,
   output logic [SYM_W-1:0] o_syn_S3,
   output logic [SYM_W-1:0] o_syn_S4,
   output logic [SYM_W-1:0] o_syn_S5,
   output logic [SYM_W-1:0] o_syn_S6,
   output logic [SYM_W-1:0] o_syn_S7,
   output logic [SYM_W-1:0] o_syn_S8,
   output logic             o_syn_short,
   output logic [1:0]       o_tp_idx,
   output logic             o_syn_valid,
   input  logic             i_syn_ready,
   output logic             o_done,
   output logic             o_abort
);

   // SETTLE_CYC is expected to be at least 1.
   localparam int               CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      HOLD_A,
      HOLD_B,
      ADV,
      SETTLE,
      DONE
   } state_t;

   state_t           state_reg;
   logic             mode_reg;
   logic [1:0]       code_reg;
   logic [1:0]       beat_cnt_reg;
   logic [CNT_W-1:0] settle_cnt_reg;
   logic [SYM_W-1:0] beat_reg [8];
   logic [SYM_W-1:0] syn_reg [8];
   logic             short_reg;
   logic             valid_reg;
   logic             next_tp_reg;
   logic             done_reg;
   logic             abort_reg;
   logic [1:0]       tp_idx_reg;

   logic [SYM_W-1:0] in_sym [8];
   logic [SYM_W-1:0] hold_a_view [8];
   logic [SYM_W-1:0] hold_b_view [8];
   logic             tpb2;
   logic [1:0]       last_beat_idx;
   logic             last_beat;
   logic             handshake;
   logic             abort_now;

   assign in_sym[0] = i_S1;
   assign in_sym[1] = i_S2;
   assign in_sym[2] = i_S3;
   assign in_sym[3] = i_S4;
   assign in_sym[4] = i_S5;
   assign in_sym[5] = i_S6;
   assign in_sym[6] = i_S7;
   assign in_sym[7] = i_S8;

   assign tpb2          = mode_reg & (code_reg != 2'b10);
   assign last_beat_idx = !mode_reg ? 2'd0 : ((code_reg == 2'b10) ? 2'd3 : 2'd1);
   assign last_beat     = (beat_cnt_reg == last_beat_idx);
   assign handshake     = valid_reg & i_syn_ready;
   assign abort_now     = !i_valid & ((state_reg == HOLD_A) | (state_reg == HOLD_B) |
                                      (state_reg == ADV)    | (state_reg == SETTLE));

   // First pattern comes straight from the switch; the second half-beat comes from the beat register.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_view
         if (gi < 4) begin : g_lo
            assign hold_a_view[gi] = in_sym[gi];
            assign hold_b_view[gi] = beat_reg[gi+4];
         end else begin : g_hi
            assign hold_a_view[gi] = tpb2 ? '0 : in_sym[gi];
            assign hold_b_view[gi] = '0;
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg      <= IDLE;
         mode_reg       <= 1'b0;
         code_reg       <= 2'b00;
         beat_cnt_reg   <= 2'd0;
         settle_cnt_reg <= '0;
         short_reg      <= 1'b0;
         valid_reg      <= 1'b0;
         next_tp_reg    <= 1'b0;
         done_reg       <= 1'b0;
         abort_reg      <= 1'b0;
         tp_idx_reg     <= 2'd0;
         for (int k = 0; k < 8; k++) begin
            beat_reg[k] <= '0;
            syn_reg[k]  <= '0;
         end
      end else begin
         next_tp_reg <= 1'b0;
         done_reg    <= 1'b0;
         abort_reg   <= 1'b0;
         // Losing the switch mid-codeword overrides everything, including a same-cycle handshake.
         if (abort_now) begin
            state_reg    <= IDLE;
            abort_reg    <= 1'b1;
            valid_reg    <= 1'b0;
            short_reg    <= 1'b0;
            tp_idx_reg   <= 2'd0;
            beat_cnt_reg <= 2'd0;
            for (int k = 0; k < 8; k++) begin
               syn_reg[k] <= '0;
            end
         end else begin
            case (state_reg)
               IDLE: begin
                  if (i_start) begin
                     mode_reg     <= i_mode;
                     code_reg     <= i_code;
                     beat_cnt_reg <= 2'd0;
                     tp_idx_reg   <= 2'd0;
                     state_reg    <= WAIT;
                  end
               end
               WAIT: begin
                  if (i_valid) begin
                     for (int k = 0; k < 8; k++) begin
                        beat_reg[k] <= in_sym[k];
                        syn_reg[k]  <= hold_a_view[k];
                     end
                     short_reg <= tpb2;
                     valid_reg <= 1'b1;
                     state_reg <= HOLD_A;
                  end
               end
               HOLD_A, HOLD_B: begin
                  if (handshake) begin
                     if ((state_reg == HOLD_A) && tpb2) begin
                        for (int k = 0; k < 8; k++) begin
                           syn_reg[k] <= hold_b_view[k];
                        end
                        tp_idx_reg <= tp_idx_reg + 2'd1;
                        state_reg  <= HOLD_B;
                     end else if (last_beat) begin
                        valid_reg  <= 1'b0;
                        short_reg  <= 1'b0;
                        tp_idx_reg <= 2'd0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                        for (int k = 0; k < 8; k++) begin
                           syn_reg[k] <= '0;
                        end
                     end else begin
                        valid_reg    <= 1'b0;
                        next_tp_reg  <= 1'b1;
                        tp_idx_reg   <= tp_idx_reg + 2'd1;
                        beat_cnt_reg <= beat_cnt_reg + 2'd1;
                        state_reg    <= ADV;
                     end
                  end
               end
               ADV: begin
                  settle_cnt_reg <= '0;
                  state_reg      <= SETTLE;
               end
               SETTLE: begin
                  if (settle_cnt_reg == SETTLE_LAST) begin
                     state_reg <= WAIT;
                  end else begin
                     settle_cnt_reg <= settle_cnt_reg + CNT_W'(1);
                  end
               end
               DONE: begin
                  state_reg <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_next_tp   = next_tp_reg;
   assign o_syn_S1    = syn_reg[0];
   assign o_syn_S2    = syn_reg[1];
   assign o_syn_S3    = syn_reg[2];
   assign o_syn_S4    = syn_reg[3];
   assign o_syn_S5    = syn_reg[4];
   assign o_syn_S6    = syn_reg[5];
   assign o_syn_S7    = syn_reg[6];
   assign o_syn_S8    = syn_reg[7];
   assign o_syn_short = short_reg;
   assign o_tp_idx    = tp_idx_reg;
   assign o_syn_valid = valid_reg;
   assign o_done      = done_reg;
   assign o_abort     = abort_reg;

endmodule

// File: tb/tb_syndrome_sequencer.sv
// Bench for syndrome_sequencer: codeword table, directed corner sequences and random codewords
// checked against a transfer-level model of the expected test patterns.
module tb_syndrome_sequencer;

   localparam int SYM_W = 10;
   localparam int SC    = 2;

   typedef logic [8*SYM_W-1:0] beat_t;
   typedef struct packed {
      logic [1:0] idx;
      logic       short_f;
      beat_t      syms;
   } xfer_t;
   typedef struct {
      logic       m;
      logic [1:0] c;
      int         n_xfer;
      int         n_pulse;
      logic       first_short;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             mode = 1'b0;
   logic [1:0]       code = 2'b00;
   logic             start = 1'b0;
   logic             valid = 1'b0;
   logic             ready = 1'b0;
   logic [SYM_W-1:0] s_in [8];
   logic             o_next_tp, o_syn_short, o_syn_valid, o_done, o_abort;
   logic [SYM_W-1:0] o_syn_S1, o_syn_S2, o_syn_S3, o_syn_S4, o_syn_S5, o_syn_S6, o_syn_S7, o_syn_S8;
   logic [1:0]       o_tp_idx;

   int    n_tests = 0;
   int    n_fail  = 0;
   xfer_t exp_q[$];
   int    exp_pulses;

   always #5 clk = ~clk;

   syndrome_sequencer #(.SETTLE_CYC(SC), .SYM_W(SYM_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_code(code), .i_start(start),
      .i_S1(s_in[0]), .i_S2(s_in[1]), .i_S3(s_in[2]), .i_S4(s_in[3]),
      .i_S5(s_in[4]), .i_S6(s_in[5]), .i_S7(s_in[6]), .i_S8(s_in[7]),
      .i_valid(valid), .o_next_tp(o_next_tp),
      .o_syn_S1(o_syn_S1), .o_syn_S2(o_syn_S2), .o_syn_S3(o_syn_S3), .o_syn_S4(o_syn_S4),
      .o_syn_S5(o_syn_S5), .o_syn_S6(o_syn_S6), .o_syn_S7(o_syn_S7), .o_syn_S8(o_syn_S8),
      .o_syn_short(o_syn_short), .o_tp_idx(o_tp_idx), .o_syn_valid(o_syn_valid),
      .i_syn_ready(ready), .o_done(o_done), .o_abort(o_abort)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic beat_t out_syms();
      return {o_syn_S1, o_syn_S2, o_syn_S3, o_syn_S4, o_syn_S5, o_syn_S6, o_syn_S7, o_syn_S8};
   endfunction

   function automatic xfer_t cur_xfer();
      return {o_tp_idx, o_syn_short, out_syms()};
   endfunction

   function automatic logic [86:0] all_out();
      return {o_next_tp, out_syms(), o_syn_short, o_tp_idx, o_syn_valid, o_done, o_abort};
   endfunction

   task automatic set_beat(input beat_t b);
      for (int k = 0; k < 8; k++) s_in[k] = b[(7-k)*SYM_W +: SYM_W];
   endtask

   // Expected transfers of one codeword, straight from the beat/test-pattern rules.
   function automatic void build_exp(input logic m, input logic [1:0] c, input beat_t d[4]);
      int beats = (m == 1'b0) ? 1 : ((c == 2'b10) ? 4 : 2);
      int tpb   = (m == 1'b1 && c != 2'b10) ? 2 : 1;
      xfer_t x;
      exp_q.delete();
      exp_pulses = beats - 1;
      for (int b = 0; b < beats; b++) begin
         for (int t = 0; t < tpb; t++) begin
            x.idx = 2'(b * tpb + t);
            if (tpb == 1) begin
               x.short_f = 1'b0;
               x.syms    = d[b];
            end else begin
               x.short_f = 1'b1;
               x.syms    = {d[b][(8-4*t)*SYM_W-1 -: 4*SYM_W], {(4*SYM_W){1'b0}}};
            end
            exp_q.push_back(x);
         end
      end
   endfunction

   // Drives one codeword as the switch would, checking every presented pattern against the model.
   task automatic run_cw(input logic m, input logic [1:0] c, input beat_t d[4], input int rdy_pct,
                         input bit noise, output int n_got, output int n_pulse, output logic first_short);
      int aborts = 0, b = 0, cyc = 0, gap = 0;
      bit gap_on = 0, adv_pend = 0, seen = 0;
      build_exp(m, c, d);
      n_got = 0; n_pulse = 0; first_short = 1'b0;
      mode = m; code = c; valid = 1'b1; ready = 1'b0; set_beat(d[0]); start = 1'b1;
      tick();
      start = 1'b0;
      if (noise) begin
         mode = ~m;
         code = 2'($urandom_range(0, 3));
      end
      while (cyc < 400 && !o_done) begin
         if (o_abort) aborts++;
         if (gap_on) begin
            if (o_syn_valid) begin
               chk_i("settle_gap", gap, SC + 1);
               gap_on = 0;
            end else gap++;
         end
         if (adv_pend) begin
            b++;
            if (b < 4) set_beat(d[b]);
            adv_pend = 0;
         end
         if (o_next_tp) begin
            n_pulse++;
            gap_on = 1; gap = 0; adv_pend = 1;
         end
         ready = ($urandom_range(1, 100) <= rdy_pct);
         start = noise && ($urandom_range(0, 9) == 0);
         if (o_syn_valid) begin
            if (!seen) begin first_short = o_syn_short; seen = 1; end
            if (n_got < exp_q.size()) chk_v("xfer", 128'(cur_xfer()), 128'(exp_q[n_got]));
            else chk_i("extra_xfer", n_got + 1, exp_q.size());
            if (ready) n_got++;
         end
         tick();
         cyc++;
      end
      start = 1'b0; ready = 1'b0;
      chk_i("done_seen", int'(o_done), 1);
      chk_i("xfer_count", n_got, exp_q.size());
      chk_i("next_tp_count", n_pulse, exp_pulses);
      chk_i("abort_none", aborts, 0);
      tick();
      chk_i("done_one_cycle", int'(o_done), 0);
      $display("[TB] cw mode=%0d code=%0d xfers=%0d next_tp=%0d", m, c, n_got, n_pulse);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!o_syn_valid && n < 20) begin tick(); n++; end
      chk_i(name, int'(o_syn_valid), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  tbl [6];
      beat_t d [4];
      xfer_t e;
      int    n_got, n_pulse;
      logic  fs;

      tbl[0] = '{1'b0, 2'b00, 1, 0, 1'b0};
      tbl[1] = '{1'b0, 2'b10, 1, 0, 1'b0};
      tbl[2] = '{1'b1, 2'b00, 4, 1, 1'b1};
      tbl[3] = '{1'b1, 2'b01, 4, 1, 1'b1};
      tbl[4] = '{1'b1, 2'b10, 4, 3, 1'b0};
      tbl[5] = '{1'b1, 2'b11, 4, 1, 1'b1};

      set_beat('0);
      rst_n = 1'b0;
      tick(); tick();
      chk_v("reset_outputs", 128'(all_out()), 128'(0));
      rst_n = 1'b1;
      tick();
      chk_v("idle_outputs", 128'(all_out()), 128'(0));

      // Codeword table; entry 0 carries S = 1..8.
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
               d[b][(7-k)*SYM_W +: SYM_W] = SYM_W'(i * 64 + b * 8 + k + 1);
         run_cw(tbl[i].m, tbl[i].c, d, 100, 1'b0, n_got, n_pulse, fs);
         chk_i("tbl_xfers", n_got, tbl[i].n_xfer);
         chk_i("tbl_pulses", n_pulse, tbl[i].n_pulse);
         chk_i("tbl_short", int'(fs), int'(tbl[i].first_short));
      end

      // Chase short code with a long stall in HOLD_B.
      mode = 1'b1; code = 2'b00; valid = 1'b1; ready = 1'b1;
      for (int k = 0; k < 8; k++) s_in[k] = SYM_W'(8'h11 + k);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      e = {2'd0, 1'b1, 10'h011, 10'h012, 10'h013, 10'h014, {(4*SYM_W){1'b0}}};
      chk_v("short_tp0", 128'(cur_xfer()), 128'(e));
      chk_i("short_tp0_valid", int'(o_syn_valid), 1);
      tick();
      ready = 1'b0;
      e = {2'd1, 1'b1, 10'h015, 10'h016, 10'h017, 10'h018, {(4*SYM_W){1'b0}}};
      chk_v("short_tp1", 128'(cur_xfer()), 128'(e));
      for (int n = 0; n < 5; n++) begin
         tick();
         chk_v("stall_hold", 128'(cur_xfer()), 128'(e));
         chk_i("stall_valid", int'(o_syn_valid), 1);
         chk_i("stall_no_next_tp", int'(o_next_tp), 0);
      end
      ready = 1'b1;
      tick();
      chk_i("short_adv_pulse", int'(o_next_tp), 1);
      chk_i("short_adv_valid", int'(o_syn_valid), 0);
      tick();
      chk_i("short_settle_pulse", int'(o_next_tp), 0);
      for (int k = 0; k < 8; k++) s_in[k] = SYM_W'(8'h21 + k);
      wait_valid("short_beat2_reached");
      e = {2'd2, 1'b1, 10'h021, 10'h022, 10'h023, 10'h024, {(4*SYM_W){1'b0}}};
      chk_v("short_tp2", 128'(cur_xfer()), 128'(e));
      tick();
      e = {2'd3, 1'b1, 10'h025, 10'h026, 10'h027, 10'h028, {(4*SYM_W){1'b0}}};
      chk_v("short_tp3", 128'(cur_xfer()), 128'(e));
      tick();
      chk_i("short_done", int'(o_done), 1);
      chk_i("short_done_valid", int'(o_syn_valid), 0);
      tick();
      chk_i("short_done_pulse_end", int'(o_done), 0);

      // Valid drops in SETTLE during a 4-beat codeword, then a clean restart.
      mode = 1'b1; code = 2'b10; valid = 1'b1; ready = 1'b1;
      for (int k = 0; k < 8; k++) s_in[k] = SYM_W'(8'h31 + k);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk_i("ab_hold_valid", int'(o_syn_valid), 1);
      tick();
      chk_i("ab_adv_pulse", int'(o_next_tp), 1);
      tick();
      valid = 1'b0;
      tick();
      chk_i("ab_abort_pulse", int'(o_abort), 1);
      chk_i("ab_no_done", int'(o_done), 0);
      chk_i("ab_valid_low", int'(o_syn_valid), 0);
      tick();
      chk_i("ab_abort_one_cycle", int'(o_abort), 0);
      chk_i("ab_tp_idx", int'(o_tp_idx), 0);
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 8; k++)
            d[b][(7-k)*SYM_W +: SYM_W] = SYM_W'(9'h100 + b * 16 + k);
      run_cw(1'b1, 2'b10, d, 100, 1'b0, n_got, n_pulse, fs);

      // Abort, handshake and start all in the same HOLD_A cycle.
      mode = 1'b0; code = 2'b00; valid = 1'b1; ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk_i("combo_hold_valid", int'(o_syn_valid), 1);
      valid = 1'b0; ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; valid = 1'b1; ready = 1'b0;
      chk_i("combo_abort", int'(o_abort), 1);
      chk_i("combo_done", int'(o_done), 0);
      chk_i("combo_valid", int'(o_syn_valid), 0);
      chk_i("combo_tp_idx", int'(o_tp_idx), 0);
      tick(); tick();
      chk_i("combo_stays_idle", int'(o_syn_valid), 0);

      // Reset pulse while holding the first pattern.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk_i("rst_hold_valid", int'(o_syn_valid), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_v("rst_mid_outputs", 128'(all_out()), 128'(0));
      tick();
      chk_v("rst_after_outputs", 128'(all_out()), 128'(0));
      tick();
      chk_v("rst_idle_outputs", 128'(all_out()), 128'(0));

      // Random codewords with random back-pressure, stray starts and mode/code changes mid-codeword.
      for (int i = 0; i < 24; i++) begin
         logic       m = 1'($urandom_range(0, 1));
         logic [1:0] c = 2'($urandom_range(0, 3));
         for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
               d[b][k*SYM_W +: SYM_W] = SYM_W'($urandom);
         run_cw(m, c, d, int'($urandom_range(30, 100)), 1'b1, n_got, n_pulse, fs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/syndrome_sequencer.md
SYNDROME_SEQUENCER -- requirements
Module: syndrome_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 1: number of cycles between an o_next_tp pulse and the next sample of i_S*, which covers the one-register latency of the syndrome switch.
REQ-002 Parameter SYM_W, default 10: width in bits of each syndrome symbol.
REQ-003 i_clk  in  1  clock; all state changes on its rising edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_mode  in  1  0 = single test pattern; 1 = Chase mode with 4 test patterns.
REQ-006 i_code  in  2  2'b10 = full 8-syndrome code; 2'b00/2'b01 = short 4-syndrome code.
REQ-007 i_start  in  1  one-cycle pulse that begins a new codeword; ignored unless the FSM is in IDLE.
REQ-008 i_S1..i_S8  in  SYM_W each  syndrome beat from the switch.
REQ-009 i_valid  in  1  syndrome beat valid from the switch.
REQ-010 o_next_tp  out  1  one-cycle pulse that advances the switch to the next beat.
REQ-011 o_syn_S1..o_syn_S8  out  SYM_W each  syndromes of one test pattern, sent downstream.
REQ-012 o_syn_short  out  1  1 = only o_syn_S1..S4 are meaningful, and o_syn_S5..S8 are driven to 0.
REQ-013 o_tp_idx  out  2  index of the test pattern currently presented, 0..3.
REQ-014 o_syn_valid  out  1  downstream valid.
REQ-015 i_syn_ready  in  1  downstream ready.
REQ-016 o_done  out  1  one-cycle pulse after the last test pattern is accepted downstream.
REQ-017 o_abort  out  1  one-cycle pulse when i_valid drops during a codeword.

Function
REQ-018 Beats per codeword (BEATS) SHALL be:
- 1 when mode=0;
- 2 when mode=1 and code != 2'b10;
- 4 when mode=1 and code = 2'b10.
REQ-019 Test patterns per beat (TPB) SHALL be 2 when mode=1 and code != 2'b10, and 1 in every other case.
REQ-020 i_mode and i_code SHALL be registered on i_start, and the registered copies SHALL be used for the whole codeword.
REQ-021 FSM states SHALL be IDLE, WAIT, HOLD_A, HOLD_B, ADV, SETTLE, DONE.
REQ-022 FSM transitions SHALL be:
- IDLE to WAIT on i_start;
- WAIT to HOLD_A when i_valid=1, capturing i_S1..S8 into the beat register in that same cycle;
- HOLD_A to HOLD_B on a handshake (o_syn_valid & i_syn_ready) when TPB=2;
- HOLD_A to ADV on a handshake when TPB=1 and beats remain;
- HOLD_B to ADV on a handshake when beats remain;
- HOLD_A or HOLD_B to DONE on the handshake of the final test pattern;
- ADV to SETTLE after 1 cycle;
- SETTLE to WAIT after SETTLE_CYC cycles;
- DONE to IDLE after 1 cycle.
REQ-023 o_next_tp SHALL be 1 only in the ADV state, for exactly 1 cycle per beat, so a codeword produces BEATS-1 pulses in total.
REQ-024 In HOLD_A with TPB=2, o_syn_S1..S4 SHALL equal the captured S1..S4, o_syn_S5..S8 SHALL be 0, and o_syn_short SHALL be 1.
REQ-025 In HOLD_B, o_syn_S1..S4 SHALL equal the captured S5..S8, o_syn_S5..S8 SHALL be 0, and o_syn_short SHALL be 1.
REQ-026 When TPB=1, o_syn_S1..S8 SHALL equal the captured S1..S8 and o_syn_short SHALL be 0.
REQ-027 o_syn_valid SHALL be 1 exactly in HOLD_A and HOLD_B.
REQ-028 Outputs SHALL be registered, and data SHALL stay stable while o_syn_valid=1 and i_syn_ready=0.
REQ-029 o_tp_idx SHALL start at 0 and increment by 1 on each downstream handshake.
REQ-030 o_tp_idx SHALL run 0..3 when mode=1 and stay at 0 when mode=0.
REQ-031 o_done SHALL pulse in the DONE state.
REQ-032 Abort: if i_valid=0 in any cycle while the FSM is in HOLD_A, HOLD_B, ADV or SETTLE, the FSM SHALL go to IDLE on the next edge and pulse o_abort for 1 cycle.
REQ-033 On abort, o_syn_valid SHALL be 0 from the next cycle, o_done SHALL stay 0, and o_tp_idx SHALL return to 0.
REQ-034 When abort and a downstream handshake occur in the same cycle, abort SHALL win and the handshake SHALL be treated as not completed.
REQ-035 i_start arriving outside IDLE SHALL be ignored.
REQ-036 i_start and abort in the same cycle SHALL produce IDLE, not WAIT.
REQ-037 A downstream stall of any length SHALL NOT drop data, produce an extra o_next_tp pulse, or change o_tp_idx.

Reset
REQ-038 With i_rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the beat register, o_syn_S1..S8 and o_tp_idx SHALL be 0.
REQ-039 With i_rst_n=0 at a clock edge, o_syn_valid, o_syn_short, o_next_tp, o_done and o_abort SHALL be 0.
REQ-040 Reset asserted in the middle of a codeword SHALL discard all progress without asserting o_abort or o_done.

Verification
REQ-041 mode=0, i_start, i_valid=1 with S1..S8 = 1..8, ready held 1 -> one transfer with S = 1..8, short=0, tp_idx=0, then o_done; no o_next_tp pulse.
REQ-042 mode=1, code=2'b10, 4 beats with distinct data, ready=1 -> 4 transfers with tp_idx 0,1,2,3, 3 o_next_tp pulses, each followed by SETTLE_CYC idle cycles, then o_done.
REQ-043 mode=1, code=2'b00, beat 1 with S1..S8 = 0x11..0x18 -> transfer {0x11..0x14, 0,0,0,0} with idx 0, then {0x15..0x18, 0,0,0,0} with idx 1; then 1 o_next_tp pulse; beat 2 gives idx 2 and 3, then o_done.
REQ-044 ready=0 for 5 cycles during HOLD_B -> outputs unchanged, no o_next_tp pulse, tp_idx stays 1.
REQ-045 i_valid dropped in SETTLE during 4-beat mode -> o_abort pulses for 1 cycle, FSM returns to IDLE, no o_done; a new i_start then restarts with tp_idx=0.
REQ-046 i_rst_n=0 for 1 cycle while in HOLD_A -> all outputs 0 on the next cycle, FSM in IDLE, no o_abort or o_done pulse.
